// File: rtl/led_sequencer.sv
// led_sequencer: strobe-driven LED pattern sequencer for an N_LEDS-wide bank.
// Modes ROTATE, BOUNCE, BAR, FREEZE; exports position, direction, wrap pulse.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_step       advance strobe (held high advances every cycle)
//   i_dir_toggle direction flip strobe
//   i_mode       requested mode, latched by i_mode_load
//   i_mode_load  mode load strobe (also recentres position)
//   o_led        registered LED drive
//   o_pos        registered position
//   o_dir        registered direction (1 = toward MSB)
//   o_mode       registered active mode
//   o_wrap       one-cycle wrap / reversal pulse
module led_sequencer #(
  parameter int   N_LEDS    = 8,
  parameter int   RESET_POS = 0,
  parameter logic RESET_DIR = 1'b0,
  localparam int  PW        = $clog2(N_LEDS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_step,
  input  logic              i_dir_toggle,
  input  logic [1:0]        i_mode,
  input  logic              i_mode_load,
  output logic [N_LEDS-1:0] o_led,
  output logic [PW-1:0]     o_pos,
  output logic              o_dir,
  output logic [1:0]        o_mode,
  output logic              o_wrap
);

  if (N_LEDS < 2 || N_LEDS > 64 ||
      RESET_POS < 0 || RESET_POS >= N_LEDS) begin : g_param_err
    $error("led_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {
    ROTATE = 2'd0,
    BOUNCE = 2'd1,
    BAR    = 2'd2,
    FREEZE = 2'd3
  } mode_e;

  localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);
  localparam logic [PW-1:0] RPOS = PW'(RESET_POS);
  localparam logic [PW-1:0] ONE  = PW'(1);
  localparam logic [N_LEDS-1:0] RLED =
    {{(N_LEDS-1){1'b0}}, 1'b1} << RESET_POS;

  mode_e             mode_q;
  mode_e             mode_n;
  logic [PW-1:0]     pos_n;
  logic              dir_n;
  logic              dir_eff;
  logic              wrap_n;
  logic [N_LEDS-1:0] led_n;

  assign o_mode = mode_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mode_q <= ROTATE;
      o_pos  <= RPOS;
      o_dir  <= RESET_DIR;
      o_led  <= RLED;
      o_wrap <= 1'b0;
    end else begin
      mode_q <= mode_n;
      o_pos  <= pos_n;
      o_dir  <= dir_n;
      o_led  <= led_n;
      o_wrap <= wrap_n;
    end
  end

  // A toggle coincident with a step steers that step.
  always_comb begin
    dir_eff = o_dir ^ i_dir_toggle;
    mode_n  = mode_q;
    pos_n   = o_pos;
    dir_n   = dir_eff;
    wrap_n  = 1'b0;
    if (i_mode_load) begin
      mode_n = mode_e'(i_mode);
      pos_n  = RPOS;
      dir_n  = o_dir;
    end else if (i_step) begin
      unique case (mode_q)
        BOUNCE: begin
          if (dir_eff && o_pos == LAST) begin
            dir_n  = 1'b0;
            pos_n  = LAST - ONE;
            wrap_n = 1'b1;
          end else if (!dir_eff && o_pos == '0) begin
            dir_n  = 1'b1;
            pos_n  = ONE;
            wrap_n = 1'b1;
          end else begin
            pos_n = dir_eff ? o_pos + ONE : o_pos - ONE;
          end
        end
        ROTATE, BAR: begin
          // Explicit wrap: N_LEDS need not be a power of two.
          if (dir_eff) begin
            wrap_n = (o_pos == LAST);
            pos_n  = wrap_n ? '0 : o_pos + ONE;
          end else begin
            wrap_n = (o_pos == '0);
            pos_n  = wrap_n ? LAST : o_pos - ONE;
          end
        end
        FREEZE: begin
        end
      endcase
    end
  end

  // Decode from next state so o_led always matches o_pos.
  always_comb begin
    led_n = '0;
    if (mode_n == BAR) begin
      for (int i = 0; i < N_LEDS; i++) begin
        led_n[i] = (i <= int'(pos_n));
      end
    end else begin
      led_n = {{(N_LEDS-1){1'b0}}, 1'b1} << pos_n;
    end
  end

endmodule
